mem_bus_arbiter: RTL

- Shares one external 32-bit word-addressed memory bus between the instruction-fetch port (IF) and the load/store port (MEM, fed by the mem-stage mem_* outputs).
- Sequences one bus transaction at a time with an ack handshake and registers read data per port.
- Raises per-stage stall requests to the pipeline ctrl block until each port's access is complete.
- Data port has priority, since the MEM instruction is older.

---
 rtl/mem_bus_arbiter_pkg.sv | 35 +++
 rtl/mem_bus_arbiter_timeout_cnt.sv | 42 ++++
 rtl/mem_bus_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared widths, enable constants, FSM encoding and bus control payload for the memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned REG_BUS_W       = 32;
    localparam int unsigned INST_ADDR_BUS_W = 32;
    localparam int unsigned SEL_W           = 4;

    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic CHIP_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam logic [SEL_W-1:0] SEL_ALL = {SEL_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_INST = 2'd2
    } arb_state_e;

    // Control half of a bus request; address and data are parameter-width and kept separate.
    typedef struct packed {
        logic             ce;
        logic             we;
        logic [SEL_W-1:0] sel;
    } bus_ctl_t;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_timeout_cnt.sv
// Loadable down-counter that flags the last cycle of an ack wait window.
module bus_timeout_cnt
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expire_c_o
);

    localparam int unsigned        CNT_W    = cnt_width(LIMIT);
    localparam logic [CNT_W-1:0]   LOAD_VAL = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload on a new grant, otherwise count down while a transaction is outstanding.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A limit of zero loads zero, so the counter never reaches one and never expires.
    assign expire_c_o = en_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between instruction fetch and load/store, data port first.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = INST_ADDR_BUS_W,
    parameter int unsigned DATA_W      = REG_BUS_W,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_ce_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_ce_i,
    input  logic              d_we_i,
    input  logic [SEL_W-1:0]  d_sel_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    input  logic              pipe_stall_i,
    input  logic              flush_i,
    output logic              stallreq_if_o,
    output logic              stallreq_mem_o,
    output logic              bus_ce_o,
    output logic              bus_we_o,
    output logic [SEL_W-1:0]  bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              bus_err_o
);

    arb_state_e        state_q,    state_d;
    bus_ctl_t          bus_ctl_q,  bus_ctl_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] d_rdata_q,  d_rdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              d_done_q,   d_done_d;
    logic              if_done_q,  if_done_d;
    logic              disc_q,     disc_d;
    logic              err_q,      err_d;

    logic d_pend_c;
    logic if_pend_c;
    logic busy_c;
    logic expire_c;
    logic finish_c;
    logic discard_c;
    logic grant_data_c;
    logic grant_inst_c;

    assign d_pend_c  = d_ce_i  & ~d_done_q;
    assign if_pend_c = if_ce_i & ~if_done_q;
    assign busy_c    = (state_q != ST_IDLE);
    assign finish_c  = busy_c & (bus_ack_i | expire_c);
    // A flush marks the running transaction as stale; it still has to finish on the bus.
    assign discard_c = disc_q | flush_i;

    // Ack-wait watchdog, restarted on every grant.
    bus_timeout_cnt #(
        .LIMIT (ACK_TIMEOUT)
    ) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .load_i     (grant_data_c | grant_inst_c),
        .en_i       (busy_c),
        .expire_c_o (expire_c)
    );

    // Next-state, grant, completion and bus-latch logic.
    always_comb begin
        state_d      = state_q;
        bus_ctl_d    = bus_ctl_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        d_rdata_d    = d_rdata_q;
        if_rdata_d   = if_rdata_q;
        d_done_d     = d_done_q;
        if_done_d    = if_done_q;
        disc_d       = disc_q;
        err_d        = 1'b0;
        grant_data_c = 1'b0;
        grant_inst_c = 1'b0;

        // Pipeline advance or flush means the next request is a new one.
        if (!pipe_stall_i || flush_i) begin
            d_done_d  = 1'b0;
            if_done_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (d_pend_c) begin
                    grant_data_c = 1'b1;
                end else if (if_pend_c) begin
                    grant_inst_c = 1'b1;
                end
            end
            ST_DATA: begin
                if (finish_c) begin
                    err_d = ~bus_ack_i;
                    if (!discard_c) begin
                        d_done_d = 1'b1;
                        if (!bus_ctl_q.we) begin
                            d_rdata_d = bus_ack_i ? bus_rdata_i : '0;
                        end
                        grant_inst_c = if_pend_c;
                    end
                end
            end
            ST_INST: begin
                if (finish_c) begin
                    err_d = ~bus_ack_i;
                    if (!discard_c) begin
                        if_done_d    = 1'b1;
                        if_rdata_d   = bus_ack_i ? bus_rdata_i : '0;
                        grant_data_c = d_pend_c;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (grant_data_c) begin
            state_d     = ST_DATA;
            bus_ctl_d   = '{ce: CHIP_ENABLE, we: d_we_i, sel: d_sel_i};
            bus_addr_d  = d_addr_i;
            bus_wdata_d = d_wdata_i;
            disc_d      = flush_i;
        end else if (grant_inst_c) begin
            state_d     = ST_INST;
            bus_ctl_d   = '{ce: CHIP_ENABLE, we: WRITE_DISABLE, sel: SEL_ALL};
            bus_addr_d  = if_addr_i;
            bus_wdata_d = '0;
            disc_d      = flush_i;
        end else if (finish_c) begin
            state_d     = ST_IDLE;
            bus_ctl_d   = '{ce: CHIP_DISABLE, we: WRITE_DISABLE, sel: '0};
            bus_addr_d  = '0;
            bus_wdata_d = '0;
            disc_d      = 1'b0;
        end else if (busy_c && flush_i) begin
            disc_d = 1'b1;
        end
    end

    // State, latched bus request, done flags and read-data registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bus_ctl_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            d_rdata_q   <= '0;
            if_rdata_q  <= '0;
            d_done_q    <= 1'b0;
            if_done_q   <= 1'b0;
            disc_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_ctl_q   <= bus_ctl_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            d_rdata_q   <= d_rdata_d;
            if_rdata_q  <= if_rdata_d;
            d_done_q    <= d_done_d;
            if_done_q   <= if_done_d;
            disc_q      <= disc_d;
            err_q       <= err_d;
        end
    end

    assign bus_ce_o       = bus_ctl_q.ce;
    assign bus_we_o       = bus_ctl_q.we;
    assign bus_sel_o      = bus_ctl_q.sel;
    assign bus_addr_o     = bus_addr_q;
    assign bus_wdata_o    = bus_wdata_q;
    assign bus_err_o      = err_q;
    assign d_rdata_o      = d_rdata_q;
    assign if_rdata_o     = if_rdata_q;
    // Stall requests must react in the same cycle as the pipeline request.
    assign stallreq_mem_o = d_pend_c;
    assign stallreq_if_o  = if_pend_c;

endmodule
